// File: rtl/fifo16_pkg.sv
// Shared constants for the 16-deep FIFO controller and its port arbiter.
package fifo16_pkg;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 16;
  localparam int COUNT_W = 5;

  // Encoding of the RAM16 rw pin.
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;
endpackage

// File: rtl/fifo16_port_arb.sv
// Single-port arbiter: decides whether this cycle's RAM access is a write
// (push) or a read (refill of the output stage). On a contest the side that
// did not get the previous grant wins, so simultaneous push/pop alternates.
module fifo16_port_arb (
  input  logic rd_req,
  input  logic full,
  input  logic wr_valid,
  input  logic last_wr,
  output logic wr_ready,
  output logic do_wr,
  output logic do_rd
);

  // wr_ready is independent of wr_valid so producers may wait on it.
  always_comb begin
    wr_ready = !full && !(rd_req && last_wr);
    do_wr    = wr_valid && wr_ready;
    do_rd    = rd_req && !do_wr;
  end

endmodule

// File: rtl/fifo16_ctrl.sv
// 16-word FIFO controller driving a single-port RAM16, with a one-word
// registered output stage (17 words total).
// Handshakes: a push transfers when wr_valid && wr_ready, a pop when
// rd_valid && rd_ready; neither ready depends on its own valid.
module fifo16_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [4:0]        count,
  output logic              full,
  output logic              empty,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);
  import fifo16_pkg::*;

  logic [ADDR_W-1:0]  wptr;
  logic [ADDR_W-1:0]  rptr;
  logic [COUNT_W-1:0] ram_count;
  logic               last_wr;
  logic               rd_req;
  logic               do_wr;
  logic               do_rd;
  logic               pop;

  // Refill the output stage whenever RAM holds data and the stage is free
  // or being emptied this cycle.
  always_comb begin
    full   = (ram_count == COUNT_W'(DEPTH));
    empty  = (ram_count == '0) && !rd_valid;
    count  = ram_count + {{(COUNT_W-1){1'b0}}, rd_valid};
    rd_req = (ram_count != '0) && (!rd_valid || rd_ready);
    pop    = rd_valid && rd_ready;
  end

  fifo16_port_arb u_arb (
    .rd_req   (rd_req),
    .full     (full),
    .wr_valid (wr_valid),
    .last_wr  (last_wr),
    .wr_ready (wr_ready),
    .do_wr    (do_wr),
    .do_rd    (do_rd)
  );

  // RAM port drive; address idles on wptr when there is no access.
  always_comb begin
    ram_en   = do_wr || do_rd;
    ram_rw   = do_wr ? RW_WRITE : RW_READ;
    ram_addr = do_rd ? rptr : wptr;
    ram_in   = wr_data;
  end

  // Pointers, occupancy and arbitration history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_count <= '0;
      last_wr   <= 1'b0;
    end else begin
      if (do_wr) begin
        wptr      <= wptr + ADDR_W'(1);
        ram_count <= ram_count + COUNT_W'(1);
        last_wr   <= 1'b1;
      end else if (do_rd) begin
        rptr      <= rptr + ADDR_W'(1);
        ram_count <= ram_count - COUNT_W'(1);
        last_wr   <= 1'b0;
      end
    end
  end

  // Output stage: load from RAM on a read, drop valid on a pop with no
  // refill; rd_data keeps its stale value when invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (do_rd) begin
      rd_valid <= 1'b1;
      rd_data  <= ram_out;
    end else if (pop) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo16_ctrl.sv
// Bench for fifo16_ctrl with a behavioural RAM16 and a queue-based model.
module tb_fifo16_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        ram_en;
  logic        ram_rw;
  logic [3:0]  ram_addr;
  logic [15:0] ram_in;
  logic [15:0] ram_out;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fifo16_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .ram_en   (ram_en),
    .ram_rw   (ram_rw),
    .ram_addr (ram_addr),
    .ram_in   (ram_in),
    .ram_out  (ram_out)
  );

  // Behavioural RAM16: combinational read, write on rising edge.
  logic [15:0] mem [16];
  assign ram_out = mem[ram_addr];
  always @(posedge clk) if (ram_en && ram_rw) mem[ram_addr] <= ram_in;

  // ---------------- scoreboard / model ----------------
  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q [$];   // every accepted word, in order
  logic [15:0] ram_q [$];   // words currently held in RAM
  logic        m_out_valid;
  logic [15:0] m_out_data;
  logic        m_last_wr;
  int          m_wr_total;
  int          m_rd_total;
  logic        last_push;
  logic        last_pop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    ram_q.delete();
    exp_q.delete();
    m_out_valid = 1'b0;
    m_out_data  = 16'h0000;
    m_last_wr   = 1'b0;
    m_wr_total  = 0;
    m_rd_total  = 0;
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic cycle(input logic wv, input logic [15:0] wd, input logic rr);
    logic e_rd_req, e_wr_ready, e_do_wr, e_do_rd;
    int n;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    #2;
    n          = ram_q.size();
    e_rd_req   = (n != 0) && (!m_out_valid || rr);
    e_wr_ready = (n != 16) && !(e_rd_req && m_last_wr);
    e_do_wr    = wv && e_wr_ready;
    e_do_rd    = e_rd_req && !e_do_wr;
    check("wr_ready", wr_ready, e_wr_ready);
    check("rd_valid", rd_valid, m_out_valid);
    check("rd_data", rd_data, m_out_data);
    check("count", count, n + int'(m_out_valid));
    check("full", full, n == 16);
    check("empty", empty, (n == 0) && !m_out_valid);
    check("ram_en", ram_en, e_do_wr || e_do_rd);
    check("ram_rw", ram_rw, e_do_wr);
    check("ram_addr", ram_addr, e_do_rd ? (m_rd_total % 16) : (m_wr_total % 16));
    check("ram_in", ram_in, wd);
    last_push = wv && wr_ready;
    last_pop  = rd_valid && rr;
    if (last_pop) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL pop_underflow observed=pop expected=no_pop");
      end else begin
        check("pop_data", rd_data, exp_q.pop_front());
      end
    end
    if (last_push) exp_q.push_back(wd);
    @(posedge clk);
    if (e_do_wr) begin
      ram_q.push_back(wd);
      m_wr_total++;
      m_last_wr = 1'b1;
    end
    if (e_do_rd) begin
      m_out_data  = ram_q.pop_front();
      m_out_valid = 1'b1;
      m_rd_total++;
      m_last_wr   = 1'b0;
    end else if (m_out_valid && rr) begin
      m_out_valid = 1'b0;
    end
    #1;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((ram_q.size() != 0 || m_out_valid) && k < 200) begin
      cycle(1'b0, 16'h0, 1'b1);
      k++;
    end
    check(tag, {31'b0, empty}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int accepted, pushed, popped, k;
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 16'h0;
    rd_ready = 1'b0;
    reset_model();
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("idle_wr_ready", wr_ready, 1);
    check("idle_ram_en", ram_en, 0);
    check("idle_full", full, 0);
    check("idle_rd_data", rd_data, 0);

    // Single push, then idle: word visible two cycles later.
    cycle(1'b1, 16'h1111, 1'b0);
    cycle(1'b0, 16'h0, 1'b0);
    #2;
    check("latency_rd_valid", rd_valid, 1);
    check("latency_rd_data", rd_data, 16'h1111);
    #8;
    drain("single_drained");

    // Fill to 17 words with the consumer stalled.
    accepted = 0;
    k = 0;
    while (accepted < 17 && k < 100) begin
      cycle(1'b1, 16'(accepted), 1'b0);
      if (last_push) accepted++;
      k++;
    end
    check("fill_accepted", accepted, 17);
    check("fill_full", full, 1);
    check("fill_count", count, 17);
    check("fill_wr_ready", wr_ready, 0);
    cycle(1'b1, 16'hBEEF, 1'b0);
    check("extra_push_rejected", last_push, 0);
    drain("fill_drained");
    check("drain_count", count, 0);
    cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);

    // Continuous push and pop of 40 words: pointers wrap.
    pushed = 0;
    popped = 0;
    k = 0;
    while ((pushed < 40 || popped < 40) && k < 1000) begin
      cycle(pushed < 40, 16'hA000 + 16'(pushed), 1'b1);
      if (last_push) pushed++;
      if (last_pop) popped++;
      k++;
    end
    check("wrap_pushed", pushed, 40);
    check("wrap_popped", popped, 40);

    // Contest with words stored: grants alternate.
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'hC000 + 16'(i), 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'hC100 + 16'(i), 1'b1);
    drain("contest_drained");

    // Randomized traffic.
    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0);
    drain("random_drained");

    // Mid-stream reset with 9 words held.
    k = 0;
    while (count != 5'd9 && k < 50) begin
      cycle(1'b1, 16'($urandom), 1'b0);
      k++;
    end
    check("pre_reset_count", count, 9);
    wr_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_count", count, 0);
    check("midrst_rd_valid", rd_valid, 0);
    check("midrst_empty", empty, 1);
    reset_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++)
      cycle($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 1) == 1);
    drain("final_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
